fetch_unit: RTL

// - Next-gen IF stage: decouples instruction fetch from decode with a parametrised fetch queue.
// - Keeps one imem request in flight and buffers returned (pc, instr) pairs.
// - Handles branch/jump redirects that arrive while a fetch is outstanding; stale responses are dropped.
// - Sits between the icache (imem_* handshake) and the IF/ID boundary; decode pops via valid/ready.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// No logic latency: types, constants and a pure function only.
// No flow control of its own.
package fetch_unit_pkg;

    // IDLE: no request out; REQ: request out, response kept; DROP: request out, response discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // jalr targets have bit 0 cleared before use
    function automatic logic [31:0] alu_mod2(input logic [31:0] a);
        return {a[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO with single-cycle flush; head is read straight from storage registers.
// Push lands in storage on the clock edge; head visible the following cycle.
// Push is ignored when full, pop ignored when empty; flush wins over both.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; the consumer qualifies the head with empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// IF stage: one imem request in flight, returned (pc, instr) pairs buffered in a fetch queue.
// imem_resp at cycle r makes the entry visible on fq_* at r+1; redirect restarts fetch the next cycle.
// New requests only issue while queue count plus in-flight stays below QDEPTH; decode pops via fq_valid/fq_ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        redirect_jalr,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        fq_valid,
    input  logic        fq_ready,
    output logic [31:0] fq_pc,
    output logic [31:0] fq_instr,
    output logic [31:0] fq_pc_next
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QDEPTH_C = (CW+1)'(QDEPTH);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  pc_nxt;
    logic [31:0]  req_addr;
    logic [31:0]  tgt;
    logic [CW-1:0] count;
    logic [CW:0]  cnt_nxt;
    logic         space_nxt;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         start_req;
    fetch_entry_t push_ent;
    fetch_entry_t head_ent;

    assign tgt = redirect_jalr ? alu_mod2(redirect_target) : redirect_target;

    // Occupancy after this cycle's push/pop; a new request may go out if it still leaves a free slot
    assign cnt_nxt   = (CW+1)'(count) + (CW+1)'(push) - (CW+1)'(pop);
    assign space_nxt = (cnt_nxt < QDEPTH_C);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state, next fetch PC, and whether a fresh request starts next cycle
    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        if (redirect)  pc_nxt = tgt;
        else if (push) pc_nxt = fetch_pc + 32'd4;
        unique case (state)
            IDLE: if (redirect || space_nxt) state_nxt = REQ;
            REQ: begin
                if (redirect)       state_nxt = imem_resp ? REQ : DROP;
                else if (imem_resp) state_nxt = space_nxt ? REQ : IDLE;
            end
            DROP: if (imem_resp) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        start_req = (state_nxt == REQ) && ((state != REQ) || imem_resp);
    end

    // Outputs of the FSM: request strobe and queue push/pop strobes
    always_comb begin
        imem_read = (state != IDLE);
        push      = (state == REQ) && imem_resp && !redirect && !fifo_full;
        pop       = fq_ready && !fifo_empty && !redirect;
        push_ent  = '{pc: fetch_pc, instr: imem_rdata};
    end

    // Request address is latched separately so it stays put while a redirect retargets fetch_pc
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            fetch_pc <= pc_nxt;
            if (start_req) req_addr <= pc_nxt;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .count    (count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign imem_address = req_addr;
    assign fq_valid     = !fifo_empty;
    assign fq_pc        = fq_valid ? head_ent.pc : '0;
    assign fq_instr     = fq_valid ? head_ent.instr : '0;
    assign fq_pc_next   = fq_valid ? (head_ent.pc + 32'd4) : '0;

endmodule
